// File: rtl/adc_cap_pkg.sv
// Shared widths, packet FSM states and the read-clock divide clamp for the ADC packet path.
// No logic of its own; imported by the packet controller and its clock divider.
package adc_cap_pkg;

    localparam int DATA_W = 18;
    localparam int ADDR_W = 10;
    localparam int DIV_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        PREFETCH,
        SEND,
        DONE
    } pkt_state_e;

    // Divide ratios below 2 cannot form a clock with both phases, so they clamp to 2.
    function automatic logic [DIV_W-1:0] div_clamp(input logic [DIV_W-1:0] clk_div);
        return (clk_div < DIV_W'(2)) ? DIV_W'(2) : clk_div;
    endfunction

endpackage

// File: rtl/adc_pkt_clkdiv.sv
// Read-clock divider: counts 0..D-1 while running, clk_rd low for the first D>>1 counts.
// Registered clk_rd, 1-cycle latency; i_en=0 freezes, i_run=0 clears to count 0 / clk_rd 0.
module adc_pkt_clkdiv
    import adc_cap_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_run,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_clk_rd,
    output logic             o_word_tick,
    output logic             o_period_end
);

    logic [DIV_W-1:0] r_div_cnt;
    logic             w_last;

    assign w_last       = (r_div_cnt == i_div - 1'b1);
    assign o_word_tick  = i_run & (r_div_cnt == '0);
    assign o_period_end = i_run & w_last;

    // clk_rd is registered from the pre-increment count, so it tracks the phase of the word on the pads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            o_clk_rd  <= 1'b0;
        end else if (i_en) begin
            if (!i_run) begin
                r_div_cnt <= '0;
                o_clk_rd  <= 1'b0;
            end else begin
                r_div_cnt <= w_last ? '0 : r_div_cnt + 1'b1;
                o_clk_rd  <= (r_div_cnt >= (i_div >> 1));
            end
        end
    end

endmodule

// File: rtl/adc_pkt_ctrl.sv
// Streams capture_len SRAM words (or a counting pattern) to the ADC pads, one per CLK_RD period.
// First word valid 2 cycles after start acceptance; no backpressure, clk_en=0 freezes all state.
module adc_pkt_ctrl
    import adc_cap_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              capture_start,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic [ADDR_W:0]   capture_len,
    input  logic              self_test_mode,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] adc_data,
    output logic              adc_data_valid,
    output logic              clk_rd,
    output logic              busy,
    output logic              done
);

    pkt_state_e        r_state;
    pkt_state_e        w_state_nxt;
    logic              r_start_d;
    logic [DIV_W-1:0]  r_div;
    logic [ADDR_W:0]   r_len;
    logic              r_st;
    logic [ADDR_W:0]   r_word_cnt;
    logic              r_rd_q;
    logic [DATA_W-1:0] r_pref;

    logic              w_start_edge;
    logic              w_word_tick;
    logic              w_period_end;
    logic [ADDR_W:0]   w_word_nxt;
    logic [DATA_W-1:0] w_pref;

    assign w_start_edge = capture_start & ~r_start_d & (r_state == IDLE);
    assign w_word_nxt   = r_word_cnt + 1'b1;
    // With D=2 the read data arrives in the very cycle it is needed, so bypass the prefetch register.
    assign w_pref       = r_rd_q ? mem_rd_data : r_pref;

    adc_pkt_clkdiv u_clkdiv (
        .clk          (clk),
        .rst          (rst),
        .i_en         (clk_en),
        .i_run        (r_state == SEND),
        .i_div        (r_div),
        .o_clk_rd     (clk_rd),
        .o_word_tick  (w_word_tick),
        .o_period_end (w_period_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else if (clk_en) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (w_start_edge) w_state_nxt = (capture_len == '0) ? DONE : PREFETCH;
            PREFETCH: w_state_nxt = SEND;
            SEND:     if (w_period_end && (r_word_cnt == r_len)) w_state_nxt = DONE;
            DONE:     w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_start_d      <= 1'b0;
            r_div          <= '0;
            r_len          <= '0;
            r_st           <= 1'b0;
            r_word_cnt     <= '0;
            r_rd_q         <= 1'b0;
            r_pref         <= '0;
            mem_rd_en      <= 1'b0;
            mem_rd_addr    <= '0;
            adc_data       <= '0;
            adc_data_valid <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else if (clk_en) begin
            r_start_d <= capture_start;
            r_rd_q    <= mem_rd_en;
            mem_rd_en <= 1'b0;
            done      <= 1'b0;
            if (r_rd_q) r_pref <= mem_rd_data;
            case (r_state)
                IDLE: begin
                    if (w_start_edge) begin
                        busy       <= 1'b1;
                        r_div      <= div_clamp(clk_div);
                        r_len      <= capture_len;
                        r_st       <= self_test_mode;
                        r_word_cnt <= '0;
                        if ((capture_len != '0) && !self_test_mode) begin
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= '0;
                        end
                    end
                end
                SEND: begin
                    if (w_word_tick) begin
                        adc_data       <= r_st ? DATA_W'(r_word_cnt) : w_pref;
                        adc_data_valid <= 1'b1;
                        r_word_cnt     <= w_word_nxt;
                        if ((w_word_nxt < r_len) && !r_st) begin
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= r_word_cnt[ADDR_W-1:0] + 1'b1;
                        end
                    end
                end
                DONE: begin
                    adc_data_valid <= 1'b0;
                    done           <= 1'b1;
                    busy           <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_pkt_ctrl.sv
// Directed bench for adc_pkt_ctrl: a packet-timeline model checked every cycle plus literal spot checks.
module tb_adc_pkt_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        capture_start;
    logic [7:0]  clk_div;
    logic [10:0] capture_len;
    logic        self_test_mode;
    logic        mem_rd_en;
    logic [9:0]  mem_rd_addr;
    logic [17:0] mem_rd_data = '0;
    logic [17:0] adc_data;
    logic        adc_data_valid;
    logic        clk_rd;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [17:0] mem [0:1023];

    adc_pkt_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .clk_en         (clk_en),
        .capture_start  (capture_start),
        .clk_div        (clk_div),
        .capture_len    (capture_len),
        .self_test_mode (self_test_mode),
        .mem_rd_en      (mem_rd_en),
        .mem_rd_addr    (mem_rd_addr),
        .mem_rd_data    (mem_rd_data),
        .adc_data       (adc_data),
        .adc_data_valid (adc_data_valid),
        .clk_rd         (clk_rd),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM: data appears the cycle after the strobe is sampled.
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

    // Packet timeline model: p counts enabled edges since the accepting edge.
    int          m_p = 0, m_E = 0, m_D = 2, m_len = 0;
    bit          m_act = 0, m_st = 0, m_sd = 0, m_idle = 0, m_cmp_on = 0;
    logic [17:0] m_last = '0;
    bit          e_busy, e_done, e_vld, e_clk, e_rd;
    logic [9:0]  e_addr;
    logic [17:0] e_dat;

    always @(posedge clk) begin
        if (rst) begin
            m_act  = 0;
            m_sd   = 0;
            m_last = '0;
        end else if (clk_en) begin
            m_idle = !m_act || (m_p >= m_E);
            if (capture_start && !m_sd && m_idle) begin
                m_act = 1;
                m_p   = 0;
                m_D   = (clk_div < 2) ? 2 : int'(clk_div);
                m_len = int'(capture_len);
                m_st  = self_test_mode;
                m_E   = (m_len == 0) ? 1 : m_len * m_D + 2;
            end else if (m_act) begin
                m_p++;
                if (m_p > m_E) m_act = 0;
            end
            m_sd = capture_start;
        end
        if (rst || clk_en) begin
            e_busy = m_act && (m_p < m_E);
            e_done = m_act && (m_p == m_E);
            e_vld  = m_act && (m_len > 0) && (m_p >= 2) && (m_p < m_E);
            e_clk  = 0;
            if (e_vld) begin
                m_last = m_st ? 18'((m_p - 2) / m_D) : mem[(m_p - 2) / m_D];
                e_clk  = ((m_p - 2) % m_D) >= (m_D / 2);
            end
            e_dat  = m_last;
            e_rd   = m_act && !m_st && (m_len > 0) &&
                     ((m_p == 0) || ((m_p >= 2) && (m_p < m_E) && ((m_p - 2) % m_D == 0) &&
                                     ((m_p - 2) / m_D < m_len - 1)));
            e_addr = (m_p == 0) ? 10'd0 : 10'((m_p - 2) / m_D + 1);
        end
        m_cmp_on = 1;
    end

    always @(negedge clk) begin
        logic [32:0] act_v, exp_v;
        if (m_cmp_on) begin
            exp_v = {e_busy, e_done, e_vld, e_clk, e_rd, (e_rd ? e_addr : 10'd0), e_dat};
            act_v = {busy, done, adc_data_valid, clk_rd, mem_rd_en, (e_rd ? mem_rd_addr : 10'd0), adc_data};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL cycle_model t=%0t {busy,done,vld,clk_rd,rd_en,addr,data}: got %h expected %h",
                         $time, act_v, exp_v);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    logic [17:0] s_dat  [0:63];
    logic        s_vld  [0:63];
    logic        s_clk  [0:63];
    logic        s_rd   [0:63];
    logic        s_busy [0:63];
    logic        s_done [0:63];

    function automatic int cnt_of(input int sel, input int a, input int b);
        int c = 0;
        for (int k = a; k <= b; k++) begin
            case (sel)
                0:       c += int'(s_vld[k]);
                1:       c += int'(s_rd[k]);
                2:       c += int'(s_done[k]);
                default: c += int'(s_clk[k]);
            endcase
        end
        return c;
    endfunction

    // Called at posedge+2 with capture_start low; the next edge accepts (index 0 = after that edge).
    task automatic start_pkt(input logic st, input logic [7:0] div, input logic [10:0] len);
        self_test_mode = st;
        clk_div        = div;
        capture_len    = len;
        capture_start  = 1'b1;
        @(posedge clk); #2;
        capture_start  = 1'b0;
    endtask

    // kind: 0 none, 1 extra start pulse, 2 ten-cycle freeze, 3 one-cycle reset.
    task automatic run_capture(input int n, input int kind, input int at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s_dat[i]  = adc_data;
            s_vld[i]  = adc_data_valid;
            s_clk[i]  = clk_rd;
            s_rd[i]   = mem_rd_en;
            s_busy[i] = busy;
            s_done[i] = done;
            if (kind == 1 && i == at)      capture_start = 1'b1;
            if (kind == 1 && i == at + 2)  capture_start = 1'b0;
            if (kind == 2 && i == at)      clk_en = 1'b0;
            if (kind == 2 && i == at + 10) clk_en = 1'b1;
            if (kind == 3 && i == at)      rst = 1'b1;
            if (kind == 3 && i == at + 1)  rst = 1'b0;
        end
        @(posedge clk); #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int n = 0; n < 1024; n++) mem[n] = 18'(32'h3FF00 + n);
        rst = 1'b1; clk_en = 1'b1; capture_start = 1'b0;
        clk_div = 8'd2; capture_len = 11'd1; self_test_mode = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            capture_start = ~capture_start;
            @(negedge clk);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_rd_en", 32'(mem_rd_en), 0);
            chk("rst_valid", 32'(adc_data_valid), 0);
        end
        @(posedge clk); #2;
        capture_start = 1'b0; rst = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;

        start_pkt(1'b1, 8'd8, 11'd4);
        run_capture(40, 0, 0);
        chk("st_busy0",   32'(s_busy[0]), 1);
        chk("st_vld1",    32'(s_vld[1]), 0);
        chk("st_vld2",    32'(s_vld[2]), 1);
        chk("st_dat2",    32'(s_dat[2]), 0);
        chk("st_dat18",   32'(s_dat[18]), 2);
        chk("st_dat33",   32'(s_dat[33]), 3);
        chk("st_clk5",    32'(s_clk[5]), 0);
        chk("st_clk6",    32'(s_clk[6]), 1);
        chk("st_clkhi",   32'(cnt_of(3, 2, 9)), 4);
        chk("st_vldcnt",  32'(cnt_of(0, 0, 39)), 32);
        chk("st_done34",  32'(s_done[34]), 1);
        chk("st_vld34",   32'(s_vld[34]), 0);
        chk("st_busy34",  32'(s_busy[34]), 0);
        chk("st_dat34",   32'(s_dat[34]), 3);
        chk("st_rdcnt",   32'(cnt_of(1, 0, 39)), 0);
        chk("st_donecnt", 32'(cnt_of(2, 0, 39)), 1);

        start_pkt(1'b0, 8'd2, 11'd5);
        run_capture(16, 0, 0);
        chk("sr_rdcnt",  32'(cnt_of(1, 0, 15)), 5);
        chk("sr_rd0",    32'(s_rd[0]), 1);
        chk("sr_dat2",   32'(s_dat[2]), 32'h3FF00);
        chk("sr_dat3",   32'(s_dat[3]), 32'h3FF00);
        chk("sr_dat6",   32'(s_dat[6]), 32'h3FF02);
        chk("sr_dat10",  32'(s_dat[10]), 32'h3FF04);
        chk("sr_vldcnt", 32'(cnt_of(0, 0, 15)), 10);
        chk("sr_done12", 32'(s_done[12]), 1);
        chk("sr_clk2",   32'(s_clk[2]), 0);
        chk("sr_clk3",   32'(s_clk[3]), 1);

        for (int d = 0; d < 2; d++) begin
            start_pkt(1'b0, 8'(d), 11'd2);
            run_capture(10, 0, 0);
            chk("clamp_vldcnt", 32'(cnt_of(0, 0, 9)), 4);
            chk("clamp_done6",  32'(s_done[6]), 1);
            chk("clamp_clk3",   32'(s_clk[3]), 1);
            chk("clamp_dat4",   32'(s_dat[4]), 32'h3FF01);
        end

        start_pkt(1'b1, 8'd3, 11'd2);
        run_capture(12, 0, 0);
        chk("odd_clk2",   32'(s_clk[2]), 0);
        chk("odd_clk3",   32'(s_clk[3]), 1);
        chk("odd_clk4",   32'(s_clk[4]), 1);
        chk("odd_clk5",   32'(s_clk[5]), 0);
        chk("odd_vldcnt", 32'(cnt_of(0, 0, 11)), 6);
        chk("odd_done8",  32'(s_done[8]), 1);
        chk("odd_dat5",   32'(s_dat[5]), 1);

        start_pkt(1'b0, 8'd4, 11'd0);
        run_capture(6, 0, 0);
        chk("zero_done1",  32'(s_done[1]), 1);
        chk("zero_busy0",  32'(s_busy[0]), 1);
        chk("zero_busy1",  32'(s_busy[1]), 0);
        chk("zero_vldcnt", 32'(cnt_of(0, 0, 5)), 0);
        chk("zero_rdcnt",  32'(cnt_of(1, 0, 5)), 0);

        start_pkt(1'b1, 8'd2, 11'd3);
        run_capture(20, 1, 3);
        chk("restart_donecnt", 32'(cnt_of(2, 0, 19)), 1);
        chk("restart_done8",   32'(s_done[8]), 1);
        chk("restart_busy10",  32'(s_busy[10]), 0);

        start_pkt(1'b0, 8'd4, 11'd3);
        run_capture(30, 2, 8);
        chk("frz_dat17",   32'(s_dat[17]), 32'h3FF01);
        chk("frz_dat23",   32'(s_dat[23]), 32'h3FF02);
        chk("frz_vldcnt",  32'(cnt_of(0, 0, 29)), 22);
        chk("frz_done24",  32'(s_done[24]), 1);
        chk("frz_donecnt", 32'(cnt_of(2, 0, 29)), 1);

        start_pkt(1'b1, 8'd2, 11'd5);
        run_capture(20, 3, 5);
        chk("rstmid_vld5",    32'(s_vld[5]), 1);
        chk("rstmid_vld6",    32'(s_vld[6]), 0);
        chk("rstmid_busy6",   32'(s_busy[6]), 0);
        chk("rstmid_dat6",    32'(s_dat[6]), 0);
        chk("rstmid_donecnt", 32'(cnt_of(2, 6, 19)), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
